// File: rtl/sync_fifo.sv
// Single-clock FIFO of DEPTH x WIDTH words with a registered read port.
// Writes into a full FIFO and reads from an empty FIFO are dropped without any error indication.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
  localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1'b1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rd_data_r;
  logic [AW-1:0]    wp_r;
  logic [AW-1:0]    rp_r;
  logic [AW:0]      count_r;
  logic             empty_s;
  logic             full_s;
  logic             wr_acc_s;
  logic             rd_acc_s;

  // Flags and accept strobes, all derived from the pre-edge occupancy.
  always_comb begin
    empty_s  = (count_r == CNT_ZERO);
    full_s   = (count_r == CNT_FULL);
    wr_acc_s = wr_en & ~full_s;
    rd_acc_s = rd_en & ~empty_s;
  end

  // Storage is never cleared; only accepted writes touch it.
  always_ff @(posedge clk) begin
    if (wr_acc_s && !rst) begin
      mem_r[wp_r] <= wr_data;
    end
  end

  // Pointers, occupancy and the read data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_r      <= PTR_ZERO;
      rp_r      <= PTR_ZERO;
      count_r   <= CNT_ZERO;
      rd_data_r <= {WIDTH{1'b0}};
    end else begin
      if (wr_acc_s) begin
        wp_r <= wp_r + PTR_ONE;
      end
      if (rd_acc_s) begin
        rp_r      <= rp_r + PTR_ONE;
        rd_data_r <= mem_r[rp_r];
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign rd_data = rd_data_r;
  assign empty   = empty_s;
  assign full    = full_s;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a queue scoreboard predicts read data and flags after every edge.
module tb_sync_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

  logic             clk;
  logic             rst;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] rd_data;
  logic             empty;
  logic             full;

  int tests_run = 0;
  int tests_failed = 0;

  logic [WIDTH-1:0] sb_q[$];
  logic [WIDTH-1:0] exp_rd = 8'h00;
  int               written = 0;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .wr_data(wr_data), .rd_data(rd_data), .empty(empty), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rd_data"}, 32'(rd_data), 32'(exp_rd));
    check({tag, ".empty"}, 32'(empty), 32'(sb_q.size() == 0));
    check({tag, ".full"}, 32'(full), 32'(sb_q.size() == DEPTH));
  endtask

  // One clock edge with the given requests; the scoreboard is updated from pre-edge occupancy.
  task automatic step(input string tag, input logic we, input logic re, input logic [WIDTH-1:0] wd);
    bit acc_w;
    bit acc_r;
    acc_w = we && (sb_q.size() < DEPTH);
    acc_r = re && (sb_q.size() > 0);
    wr_en = we;
    rd_en = re;
    wr_data = wd;
    @(posedge clk);
    #1;
    if (acc_r) exp_rd = sb_q.pop_front();
    if (acc_w) sb_q.push_back(wd);
    wr_en = 1'b0;
    rd_en = 1'b0;
    wr_data = 8'hxx;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    wr_en = 1'b1;
    rd_en = 1'b0;
    wr_data = 8'h55;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wr_en = 1'b0;
    sb_q.delete();
    exp_rd = 8'h00;
    check_all(tag);
  endtask

  task automatic drain(input string tag);
    while (sb_q.size() > 0) step(tag, 1'b0, 1'b1, 8'h00);
  endtask

  initial begin
    rst = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    wr_data = 8'h00;
    @(posedge clk);
    #1;

    do_reset("reset");
    step("reset_not_stored", 1'b0, 1'b1, 8'h00);

    for (int i = 1; i <= 3; i++) step("ordered_wr", 1'b1, 1'b0, 8'(i));
    step("ordered_rd", 1'b0, 1'b1, 8'h00);
    check("ordered_rd1", 32'(rd_data), 32'h1);
    step("ordered_rd", 1'b0, 1'b1, 8'h00);
    check("ordered_rd2", 32'(rd_data), 32'h2);
    check("ordered_one_left", 32'(empty), 32'h0);
    drain("ordered_drain");

    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 1'b0, 8'(i));
    check("fill_full", 32'(full), 32'h1);
    step("overflow", 1'b1, 1'b0, 8'hAA);
    for (int i = 0; i < DEPTH; i++) begin
      step("fill_rd", 1'b0, 1'b1, 8'h00);
      check("fill_order", 32'(rd_data), 32'(i));
    end
    check("fill_empty", 32'(empty), 32'h1);

    step("underflow", 1'b0, 1'b1, 8'h00);
    check("underflow_hold", 32'(rd_data), 32'hF);

    for (int i = 0; i < 3; i++) step("simul_pre", 1'b1, 1'b0, 8'(8'h20 + i));
    for (int i = 0; i < 5; i++) step("simul_mid", 1'b1, 1'b1, 8'(10 + i));
    check("simul_mid_last", 32'(rd_data), 32'd11);
    drain("simul_mid_drain");

    for (int i = 0; i < 5; i++) step("simul_empty", 1'b1, 1'b1, 8'(10 + i));
    drain("simul_empty_drain");

    for (int i = 0; i < DEPTH; i++) step("simul_full_pre", 1'b1, 1'b0, 8'(8'h40 + i));
    step("simul_full_first", 1'b1, 1'b1, 8'd10);
    check("simul_full_deassert", 32'(full), 32'h0);
    for (int i = 1; i < 5; i++) step("simul_full", 1'b1, 1'b1, 8'(10 + i));
    drain("simul_full_drain");

    written = 0;
    while (written < 40) begin
      bit we;
      bit re;
      if (sb_q.size() == 0) begin
        we = 1'b1; re = 1'b0;
      end else if (sb_q.size() >= 10) begin
        we = 1'b0; re = 1'b1;
      end else if (sb_q.size() == 1) begin
        we = 1'b1; re = 1'($urandom_range(1, 0));
      end else begin
        we = 1'($urandom_range(1, 0)); re = 1'($urandom_range(1, 0));
      end
      if (we) written++;
      step("wrap", we, re, 8'(8'h80 + written));
    end
    drain("wrap_drain");

    for (int i = 0; i < 7; i++) step("midrst_pre", 1'b1, 1'b0, 8'(8'h60 + i));
    do_reset("midrst");
    step("midrst_wr", 1'b1, 1'b0, 8'h77);
    step("midrst_rd", 1'b0, 1'b1, 8'h00);
    check("midrst_new_word", 32'(rd_data), 32'h77);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
